m_stage_io_ctrl: RTL and testbench

Memory-stage control block for the pipelined processor. It decodes the M-stage instruction into the data-memory write enable and the button-read control. It also owns all game-controller input conditioning: synchronisation, per-button debounce, and sticky press-edge latches for N_CTRL controllers of BTNS buttons each. An `sbp` instruction reads one button, either as its debounced level or as a consume-on-read press event, so software cannot miss short presses between polls.

---
 rtl/m_stage_io_ctrl_pkg.sv | 32 +++
 rtl/m_stage_io_ctrl_if.sv | 24 ++
 rtl/m_stage_io_ctrl_btn.sv | 63 ++++++
 rtl/m_stage_io_ctrl.sv | 70 +++++++
 tb/tb_m_stage_io_ctrl.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/m_stage_io_ctrl_pkg.sv
// Shared constants and instruction field decode for the M-stage I/O control slice.
package m_io_pkg;

  localparam logic [4:0] OP_SW  = 5'b00111;
  localparam logic [4:0] OP_SBP = 5'b10111;

  localparam int BTN_IDX_LSB  = 0;
  localparam int CTRL_IDX_LSB = 4;
  localparam int MODE_BIT     = 16;
  localparam int IDX_W        = 4;

  localparam int MAX_CTRL = 16;
  localparam int MAX_BTNS = 16;

  typedef struct packed {
    logic [4:0]       opcode;
    logic             mode;
    logic [IDX_W-1:0] ctrl_idx;
    logic [IDX_W-1:0] btn_idx;
  } m_fields_t;

  // Pull the opcode and sbp operand fields out of a 32-bit instruction word.
  function automatic m_fields_t decode_fields(input logic [31:0] instr);
    m_fields_t f;
    f.opcode   = instr[31:27];
    f.mode     = instr[MODE_BIT];
    f.ctrl_idx = instr[CTRL_IDX_LSB +: IDX_W];
    f.btn_idx  = instr[BTN_IDX_LSB +: IDX_W];
    return f;
  endfunction

endpackage

// File: rtl/m_stage_io_ctrl_if.sv
// M-stage instruction/stall inputs, raw controller pins and button-side results.
interface m_stage_io_if #(
  parameter int N_CTRL = 2,
  parameter int BTNS   = 8
);
  logic [31:0]            instr;
  logic                   stall;
  logic [N_CTRL*BTNS-1:0] ctrl_in;
  logic                   mem_we;
  logic                   sbp;
  logic                   bval;
  logic [N_CTRL*BTNS-1:0] btn_state;
  logic [N_CTRL*BTNS-1:0] edge_pend;

  modport master (
    output instr, stall, ctrl_in,
    input  mem_we, sbp, bval, btn_state, edge_pend
  );

  modport slave (
    input  instr, stall, ctrl_in,
    output mem_we, sbp, bval, btn_state, edge_pend
  );
endinterface

// File: rtl/m_stage_io_ctrl_btn.sv
// One button pin: two-flop synchroniser, debounce counter and sticky press latch.
module btn_conditioner #(
  parameter int DB_CYCLES  = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  input  logic consume,
  output logic deb,
  output logic pend
);

  localparam int CNT_W = $clog2(DB_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             sync_p0;
  logic             sync_p1;
  logic             sync_lvl;
  logic [CNT_W-1:0] cnt;
  logic             flip;
  logic             rise;

  // Stage p0 -> p1: metastability filter on the asynchronous pin.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= pin;
      sync_p1 <= sync_p0;
    end
  end

  assign sync_lvl = sync_p1 ^ ACTIVE_LOW;
  assign flip     = (sync_lvl != deb) && (cnt == CNT_LAST);
  assign rise     = flip & ~deb;

  // Debounce: flip only after DB_CYCLES consecutive disagreeing samples.
  always_ff @(posedge clock) begin
    if (reset) begin
      deb <= 1'b0;
      cnt <= '0;
    end else if (sync_lvl == deb) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      deb <= ~deb;
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Press latch: a new press outranks a same-cycle consuming read.
  always_ff @(posedge clock) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      pend <= rise | (pend & ~consume);
    end
  end

endmodule

// File: rtl/m_stage_io_ctrl.sv
// M-stage control: sw/sbp decode, per-button conditioning and the sbp read mux.
module m_stage_io_ctrl
  import m_io_pkg::*;
#(
  parameter int N_CTRL     = 2,
  parameter int BTNS       = 8,
  parameter int DB_CYCLES  = 4,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic         clock,
  input  logic         reset,
  m_stage_io_if.slave  io
);

  localparam int NB = N_CTRL * BTNS;

  if (N_CTRL < 1 || N_CTRL > MAX_CTRL || BTNS < 1 || BTNS > MAX_BTNS || DB_CYCLES < 1)
  begin : g_bad_param
    $error("m_stage_io_ctrl: parameter out of supported range");
  end

  m_fields_t         f;
  logic              is_sbp;
  logic              consume_req;
  logic [NB-1:0]     deb_vec;
  logic [NB-1:0]     pend_vec;
  logic              bval_c;

  assign f           = decode_fields(io.instr);
  assign is_sbp      = (f.opcode == OP_SBP);
  assign consume_req = is_sbp & f.mode & ~io.stall;

  assign io.mem_we    = (f.opcode == OP_SW) & ~io.stall;
  assign io.sbp       = is_sbp;
  assign io.btn_state = deb_vec;
  assign io.edge_pend = pend_vec;
  assign io.bval      = bval_c;

  for (genvar c = 0; c < N_CTRL; c++) begin : g_ctrl
    for (genvar b = 0; b < BTNS; b++) begin : g_btn
      localparam int I = c * BTNS + b;
      logic hit;
      assign hit = consume_req && (f.ctrl_idx == IDX_W'(c)) && (f.btn_idx == IDX_W'(b));
      btn_conditioner #(
        .DB_CYCLES  (DB_CYCLES),
        .ACTIVE_LOW (ACTIVE_LOW)
      ) u_btn (
        .clock   (clock),
        .reset   (reset),
        .pin     (io.ctrl_in[I]),
        .consume (hit),
        .deb     (deb_vec[I]),
        .pend    (pend_vec[I])
      );
    end
  end

  // Read mux: only an exact in-range (controller, button) match can return 1.
  always_comb begin
    bval_c = 1'b0;
    for (int c = 0; c < N_CTRL; c++) begin
      for (int b = 0; b < BTNS; b++) begin
        if (is_sbp && (f.ctrl_idx == c[IDX_W-1:0]) && (f.btn_idx == b[IDX_W-1:0])) begin
          bval_c = f.mode ? pend_vec[c*BTNS+b] : deb_vec[c*BTNS+b];
        end
      end
    end
  end

endmodule

// File: tb/tb_m_stage_io_ctrl.sv
// Directed bench for m_stage_io_ctrl: decode, debounce timing, consume, stall, range, reset, active-low.
module tb_m_stage_io_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  m_stage_io_if #(.N_CTRL(2), .BTNS(8)) io_a ();
  m_stage_io_if #(.N_CTRL(1), .BTNS(1)) io_b ();

  m_stage_io_ctrl #(.N_CTRL(2), .BTNS(8), .DB_CYCLES(4), .ACTIVE_LOW(1'b0)) dut_a (
    .clock (clk),
    .reset (rst),
    .io    (io_a)
  );

  m_stage_io_ctrl #(.N_CTRL(1), .BTNS(1), .DB_CYCLES(4), .ACTIVE_LOW(1'b1)) dut_b (
    .clock (clk),
    .reset (rst),
    .io    (io_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk_sbp(input int c, input int b, input int m);
    logic [31:0] v;
    v        = '0;
    v[31:27] = 5'b10111;
    v[16]    = m[0];
    v[7:4]   = c[3:0];
    v[3:0]   = b[3:0];
    return v;
  endfunction

  initial begin
    logic [15:0] snap;
    rst           = 1'b1;
    io_a.instr    = '0;
    io_a.stall    = 1'b0;
    io_a.ctrl_in  = '0;
    io_b.instr    = '0;
    io_b.stall    = 1'b0;
    io_b.ctrl_in  = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_state_a", 32'(io_a.btn_state), 32'h0);
    chk("rst_pend_a",  32'(io_a.edge_pend), 32'h0);
    chk("rst_state_b", 32'(io_b.btn_state), 32'h0);

    // Decode
    io_a.instr = {5'b00111, 27'h0};
    #1;
    chk("sw_we",  32'(io_a.mem_we), 32'h1);
    chk("sw_sbp", 32'(io_a.sbp),    32'h0);
    io_a.stall = 1'b1;
    #1;
    chk("sw_stall_we", 32'(io_a.mem_we), 32'h0);
    io_a.instr = {5'b10111, 27'h0};
    #1;
    chk("sbp_stall_sbp", 32'(io_a.sbp), 32'h1);
    io_a.stall = 1'b0;
    #1;
    chk("sbp_sbp", 32'(io_a.sbp),    32'h1);
    chk("sbp_we",  32'(io_a.mem_we), 32'h0);
    io_a.instr = '0;
    #1;
    chk("nop_decode", 32'({io_a.sbp, io_a.mem_we, io_a.bval}), 32'h0);

    // Debounce latency on bit 9
    tick();
    io_a.ctrl_in[9] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("lat9_state_k%0d", k), 32'(io_a.btn_state[9]), 32'(k == 6));
      chk($sformatf("lat9_pend_k%0d", k),  32'(io_a.edge_pend[9]), 32'(k == 6));
    end
    chk("b_idle_state", 32'(io_b.btn_state), 32'h0);

    // 3-cycle glitch on bit 2 never registers
    io_a.ctrl_in[2] = 1'b1;
    tick(); tick(); tick();
    io_a.ctrl_in[2] = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk($sformatf("glitch2_k%0d", k), 32'({io_a.btn_state[2], io_a.edge_pend[2]}), 32'h0);
    end

    // 4-cycle pulse on bit 3 is exactly long enough
    io_a.ctrl_in[3] = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 4) io_a.ctrl_in[3] = 1'b0;
      if (k >= 5) chk($sformatf("pulse3_k%0d", k), 32'({io_a.btn_state[3], io_a.edge_pend[3]}),
                      (k == 6) ? 32'h3 : 32'h0);
    end
    for (int k = 0; k < 6; k++) tick();
    chk("release3_state", 32'(io_a.btn_state[3]), 32'h0);
    chk("release3_pend",  32'(io_a.edge_pend[3]), 32'h1);

    // Edge consume on controller 1 button 1
    io_a.instr = mk_sbp(1, 1, 1);
    #1;
    chk("consume9_bval", 32'(io_a.bval), 32'h1);
    tick();
    chk("consume9_clr", 32'(io_a.edge_pend[9]), 32'h0);
    chk("consume9_keep3", 32'(io_a.edge_pend[3]), 32'h1);
    chk("reread9_bval", 32'(io_a.bval), 32'h0);
    io_a.instr = mk_sbp(1, 1, 0);
    #1;
    chk("level9_bval", 32'(io_a.bval), 32'h1);
    io_a.instr = mk_sbp(0, 3, 0);
    #1;
    chk("level3_bval", 32'(io_a.bval), 32'h0);

    // Stalled consume holds the latch; first unstalled cycle clears it
    io_a.instr = mk_sbp(0, 3, 1);
    io_a.stall = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      #1;
      chk($sformatf("stall3_bval_k%0d", k), 32'(io_a.bval), 32'h1);
      tick();
      chk($sformatf("stall3_pend_k%0d", k), 32'(io_a.edge_pend[3]), 32'h1);
    end
    io_a.stall = 1'b0;
    #1;
    chk("unstall3_bval", 32'(io_a.bval), 32'h1);
    tick();
    chk("unstall3_clr", 32'(io_a.edge_pend[3]), 32'h0);
    io_a.instr = '0;

    // Press edge coincident with a consume: set wins
    io_a.ctrl_in[9] = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    chk("rel9_state", 32'(io_a.btn_state[9]), 32'h0);
    io_a.ctrl_in[9] = 1'b1;
    for (int k = 0; k < 5; k++) tick();
    io_a.instr = mk_sbp(1, 1, 1);
    #1;
    chk("coll9_bval_before", 32'(io_a.bval), 32'h0);
    tick();
    chk("coll9_pend", 32'(io_a.edge_pend[9]), 32'h1);
    chk("coll9_state", 32'(io_a.btn_state[9]), 32'h1);
    chk("coll9_bval_after", 32'(io_a.bval), 32'h1);
    io_a.instr = '0;

    // Out-of-range reads return 0 and consume nothing
    snap = io_a.edge_pend;
    io_a.instr = mk_sbp(3, 1, 1);
    #1;
    chk("oor_ctrl_bval", 32'(io_a.bval), 32'h0);
    tick();
    chk("oor_ctrl_pend", 32'(io_a.edge_pend), 32'(snap));
    io_a.instr = mk_sbp(0, 9, 1);
    #1;
    chk("oor_btn_bval", 32'(io_a.bval), 32'h0);
    tick();
    chk("oor_btn_pend", 32'(io_a.edge_pend), 32'(snap));
    io_a.instr = mk_sbp(1, 9, 0);
    #1;
    chk("oor_btn_level", 32'(io_a.bval), 32'h0);
    io_a.instr = '0;

    // Reset mid-debounce with buttons held
    io_a.ctrl_in[0] = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_state", 32'(io_a.btn_state), 32'h0);
    chk("rst2_pend",  32'(io_a.edge_pend), 32'h0);
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("rst2_state_k%0d", k), 32'(io_a.btn_state), (k == 6) ? 32'h0201 : 32'h0);
      chk($sformatf("rst2_pend_k%0d", k),  32'(io_a.edge_pend), (k == 6) ? 32'h0201 : 32'h0);
    end

    // Active-low controller: pin driven 0 means pressed
    chk("al_idle", 32'(io_b.btn_state), 32'h0);
    io_b.ctrl_in = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("al_state_k%0d", k), 32'(io_b.btn_state), 32'(k == 6));
    end
    io_b.instr = mk_sbp(0, 0, 0);
    #1;
    chk("al_level_bval", 32'(io_b.bval), 32'h1);
    io_b.instr = mk_sbp(0, 0, 1);
    #1;
    chk("al_edge_bval", 32'(io_b.bval), 32'h1);
    tick();
    chk("al_edge_clr", 32'(io_b.edge_pend), 32'h0);
    io_b.instr = '0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
